// File: rtl/out_stream_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// out_stream_buffer_pkg : shared state encoding and SoC default sizes
// Revision: 1.0
// ---------------------------------------------------------------------------
package out_stream_buffer_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HELD = 1'b1
   } cpu_state_t;

   localparam int OSB_DATA_W = 16;
   localparam int OSB_DEPTH  = 8;

endpackage
`default_nettype wire

// File: rtl/out_stream_buffer_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : DATA_W x DEPTH first-word fall-through FIFO with level count
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == DEPTH_LVL);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (ADDR_W+1)'(1);
            2'b01:   level <= level - (ADDR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/out_stream_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// out_stream_buffer : CPU out_req/out_ack capture into a FIFO drained by valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module out_stream_buffer
   import out_stream_buffer_pkg::*;
#(
   parameter int DATA_W = OSB_DATA_W,
   parameter int DEPTH  = OSB_DEPTH,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              out_req,
   input  logic [DATA_W-1:0] out_data,
   output logic              out_ack,
   output logic              snk_valid,
   output logic [DATA_W-1:0] snk_data,
   input  logic              snk_ready,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty
);

   cpu_state_t state;
   cpu_state_t state_nxt;
   logic       push;
   logic       pop;

   assign snk_valid = ~empty;
   assign pop       = snk_valid & snk_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state   <= IDLE;
         out_ack <= 1'b0;
      end else begin
         state   <= state_nxt;
         out_ack <= push;
      end
   end

   // One request level moves exactly one word; a full FIFO leaves it pending.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (out_req && !full) begin
               push      = 1'b1;
               state_nxt = HELD;
            end
         end
         HELD: begin
            if (!out_req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push    (push),
      .wr_data (out_data),
      .pop     (pop),
      .rd_data (snk_data),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_out_stream_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_out_stream_buffer : directed vectors plus scoreboarded streaming sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_out_stream_buffer;

   logic        clk = 1'b0;
   logic        rst_b = 1'b1;
   logic        out_req = 1'b0;
   logic [15:0] out_data = '0;
   logic        out_ack;
   logic        snk_valid;
   logic [15:0] snk_data;
   logic        snk_ready = 1'b0;
   logic [3:0]  level;
   logic        full;
   logic        empty;

   int          checks = 0;
   int          errors = 0;
   int          mode = 0;        // 0: manual ready, 1: always ready, 2: random ready
   logic        man_rdy = 1'b0;
   logic [15:0] sb_q[$];
   int          ack_cnt = 0;
   int          max_lvl = 0;

   typedef struct {
      logic        req;
      logic [15:0] data;
      logic        rdy;
      logic        ack;
      logic        valid;
      logic        chk_data;
      logic [15:0] exp_data;
      logic [3:0]  lvl;
   } vec_t;

   vec_t vecs[14];

   out_stream_buffer dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .out_req   (out_req),
      .out_data  (out_data),
      .out_ack   (out_ack),
      .snk_valid (snk_valid),
      .snk_data  (snk_data),
      .snk_ready (snk_ready),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sink model: ready is updated away from the rising edge, pops are scored.
   always @(negedge clk) begin
      case (mode)
         0:       snk_ready = man_rdy;
         1:       snk_ready = 1'b1;
         default: snk_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode != 0) begin
         if (snk_valid && snk_ready) begin
            if (sb_q.size() == 0) chk("sb_extra_word", 32'(snk_data), 32'hFFFF_FFFF);
            else chk("sb_order", 32'(snk_data), 32'(sb_q.pop_front()));
         end
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (out_ack) ack_cnt++;
      end
   end

   task automatic send(input logic [15:0] d, input int bound, input bit track, output bit got);
      got      = 1'b0;
      out_req  = 1'b1;
      out_data = d;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (out_ack) begin
            got = 1'b1;
            if (track) sb_q.push_back(d);
            break;
         end
      end
      out_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain_wait(input int bound);
      for (int i = 0; i < bound && sb_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      bit got;
      int nack;

      vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
      vecs[1]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[2]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[3]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[4]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[5]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[6]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd1};
      vecs[8]  = '{1'b1, 16'h5678, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 4'd2};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5678, 4'd1};
      vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
      vecs[11] = '{1'b1, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b1, 16'hABCD, 4'd1};
      vecs[12] = '{1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
      vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};

      // Reset values, then release mid-cycle.
      #1 rst_b = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_ack", 32'(out_ack), 32'd0);
      chk("rst_valid", 32'(snk_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      #2 rst_b = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("post_rst_level", 32'(level), 32'd0);
      chk("post_rst_ack", 32'(out_ack), 32'd0);

      // Directed vector table.
      for (int i = 0; i < 14; i++) begin
         out_req  = vecs[i].req;
         out_data = vecs[i].data;
         man_rdy  = vecs[i].rdy;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_ack", i), 32'(out_ack), 32'(vecs[i].ack));
         chk($sformatf("vec%0d_valid", i), 32'(snk_valid), 32'(vecs[i].valid));
         chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
         chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].lvl == 4'd8));
         chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].lvl == 4'd0));
         if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), 32'(snk_data), 32'(vecs[i].exp_data));
      end

      // Fill to full, blocked 9th request, single pop then late capture.
      nack = 0;
      for (int k = 1; k <= 8; k++) begin
         send(16'(k), 5, 1'b0, got);
         if (got) nack++;
      end
      chk("fill_acks", 32'(nack), 32'd8);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_level", 32'(level), 32'd8);
      out_req  = 1'b1;
      out_data = 16'h0009;
      nack = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (out_ack) nack++;
      end
      chk("full_no_ack", 32'(nack), 32'd0);
      chk("full_level_held", 32'(level), 32'd8);
      man_rdy = 1'b1;
      @(posedge clk); #1;
      man_rdy = 1'b0;
      chk("full_pop_level", 32'(level), 32'd7);
      chk("full_pop_no_ack", 32'(out_ack), 32'd0);
      chk("full_pop_head", 32'(snk_data), 32'h0002);
      @(posedge clk); #1;
      chk("late_ack", 32'(out_ack), 32'd1);
      chk("late_level", 32'(level), 32'd8);
      out_req = 1'b0;
      man_rdy = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         chk($sformatf("drain_word%0d", k), 32'(snk_data), 32'(k));
         @(posedge clk); #1;
      end
      man_rdy = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);

      // Continuous stream with the sink always ready.
      max_lvl = 0;
      ack_cnt = 0;
      mode    = 1;
      nack    = 0;
      for (int k = 0; k < 20; k++) begin
         send(16'h0100 + 16'(k), 10, 1'b1, got);
         if (got) nack++;
      end
      drain_wait(50);
      chk("stream_sent", 32'(nack), 32'd20);
      chk("stream_max_le2", 32'(max_lvl <= 2), 32'd1);
      mode = 0;
      @(posedge clk); #1;

      // Random words against a randomly stalling sink.
      ack_cnt = 0;
      mode    = 2;
      for (int k = 0; k < 100; k++) begin
         send(16'($urandom), 200, 1'b1, got);
         if (!got) chk("rand_send_timeout", 32'd0, 32'd1);
      end
      drain_wait(1000);
      chk("rand_ack_count", 32'(ack_cnt), 32'd100);
      mode = 0;
      @(posedge clk); #1;

      // Asynchronous reset while HELD with five words stored.
      for (int k = 0; k < 4; k++) send(16'hA0A0 + 16'(k), 5, 1'b0, got);
      out_req  = 1'b1;
      out_data = 16'hA0A4;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_level", 32'(level), 32'd5);
      #2 rst_b = 1'b0;
      #1;
      chk("async_rst_ack", 32'(out_ack), 32'd0);
      chk("async_rst_valid", 32'(snk_valid), 32'd0);
      chk("async_rst_level", 32'(level), 32'd0);
      chk("async_rst_full", 32'(full), 32'd0);
      chk("async_rst_empty", 32'(empty), 32'd1);
      out_req = 1'b0;
      @(posedge clk); #3 rst_b = 1'b1;
      @(posedge clk); #1;
      chk("after_rst_level", 32'(level), 32'd0);
      send(16'h7777, 5, 1'b0, got);
      chk("after_rst_ack", 32'(got), 32'd1);
      chk("after_rst_head", 32'(snk_data), 32'h7777);
      chk("after_rst_count", 32'(level), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/out_stream_buffer.md
Name: out_stream_buffer

Overview:
- Buffered output stage that sits directly downstream of the CPU output port, in the slot the plain output unit occupies today.
- Accepts 16-bit words from the CPU over the out_req/out_data/out_ack handshake and stores them in a DEPTH-entry FIFO.
- Drains the FIFO to an external sink through a valid/ready stream, so the CPU never stalls on a slow consumer until the FIFO is full.

Parameters:
- DATA_W, 16, width of out_data, snk_data and the FIFO words.
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3, log2(DEPTH); width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- out_req  input  1  CPU output request, level; out_data is valid while high.
- out_data  input  DATA_W  word from the CPU.
- out_ack  output  1  one-cycle pulse: the word has been captured.
- snk_valid  output  1  snk_data holds the FIFO head word.
- snk_data  output  DATA_W  FIFO head word.
- snk_ready  input  1  sink accepts the head word this cycle.
- level  output  ADDR_W+1  number of stored words, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- Interface: one clock, clk; reset rst_b is asynchronous and active-low.
- Reset values while rst_b=0: out_ack=0, snk_valid=0, level=0, full=0, empty=1, pointers=0, held=0.
  - FIFO storage is not reset.
  - snk_data is don't-care while empty.
- CPU-side state machine, two states:
  - IDLE: waiting for a new request.
  - HELD: word captured; waiting for out_req to drop.
- push = (state==IDLE) & out_req & !full, with full taken from the registered level.
  - On push: mem[wr_ptr] <= out_data, wr_ptr+1 wraps modulo DEPTH, state moves to HELD.
  - out_ack is registered and is 1 in the cycle after push, for exactly one cycle.
- In HELD, out_req=1 causes no further capture. out_req=0 returns the block to IDLE at the next edge.
  - So one request level transfers exactly one word.
  - The minimum back-to-back spacing is 3 cycles: req, ack, req low.
- Full FIFO: the request stays pending with no ack and no capture. Capture happens in the first cycle the registered level < DEPTH while out_req is still high.
- Sink side, first-word fall-through:
  - snk_valid = !empty.
  - snk_data = mem[rd_ptr], read combinationally from registered storage.
  - pop = snk_valid & snk_ready; rd_ptr+1 wraps.
  - snk_data must be stable while snk_valid=1 and snk_ready=0.
- Latency: push at cycle n gives snk_valid=1 in cycle n+1 when the FIFO was empty.
- Simultaneous push and pop: level is unchanged and both pointers advance.
  - Legal at any level 0 < level < DEPTH.
  - At level == DEPTH only the pop occurs. The pending push happens on the following cycle.
- level update: level + push - pop, computed in ADDR_W+1 bits.
  - It never exceeds DEPTH and never underflows, guaranteed by the gating above.
- Reset mid-operation: all stored words are discarded and state returns to IDLE.
  - If the CPU still holds out_req after reset, the word is captured again. The CPU resets on the same rst_b, so this does not arise in the SoC.
- No combinational path from out_req to out_ack.
- No combinational path from snk_ready to snk_valid or snk_data.

Decomposition:
- Shared package holds:
  - the CPU-side state encoding, IDLE=1'b0 and HELD=1'b1;
  - the default DATA_W and DEPTH constants used by the SoC top.
- One sub-module is natural: sync_fifo, a parameterised DATA_W x DEPTH FIFO with push/pop, head data, level, full and empty.
- out_stream_buffer wraps sync_fifo with the CPU handshake state machine and the out_ack register.

Test Plan:
- Reset with out_req=0 and snk_ready=0 → out_ack=0, snk_valid=0, level=0, empty=1, full=0. Release rst_b mid-cycle and confirm no spurious state change.
- Single word 0x1234 with snk_ready=0 → out_ack high exactly the next cycle, snk_valid=1, snk_data=0x1234, level=1. Holding out_req high for 5 more cycles leaves level=1 with no second ack.
- Push 8 words 0x0001..0x0008 with snk_ready=0 → full=1, level=8. A 9th request 0x0009 gets no ack. Pulse snk_ready for one cycle: 0x0001 is popped, then 0x0009 is captured and acked, level=8.
- Continuous stream of 20 words with snk_ready=1 → words emerge in order with no loss or duplication. level never exceeds 2. Pointer wrap past index 7 is exercised.
- Random snk_ready at 50%, CPU sends 100 random words → scoreboard matches order exactly. Exactly 100 out_ack pulses.
- Assert rst_b=0 while level=5 and out_req=1 in HELD → all outputs return to reset values asynchronously. Previously stored words never appear on snk_data.
